// File: rtl/vx_stream_rsp_xbar.sv
// Response-return crossbar: routes tagged responses from NUM_SRCS sources back to NUM_DSTS
// requesters via per-destination round-robin arbiters and 2-entry registered skid buffers.
module vx_stream_rsp_xbar #(
  parameter int NUM_SRCS      = 4,
  parameter int NUM_DSTS      = 4,
  parameter int DATAW         = 32,
  parameter int PERF_CTR_BITS = 16,
  parameter int SRC_WIDTH     = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1,
  parameter int DST_WIDTH     = (NUM_DSTS > 1) ? $clog2(NUM_DSTS) : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_SRCS-1:0]                 valid_in,
  input  logic [NUM_SRCS-1:0][DATAW-1:0]      data_in,
  input  logic [NUM_SRCS-1:0][DST_WIDTH-1:0]  dst_in,
  output logic [NUM_SRCS-1:0]                 ready_in,
  output logic [NUM_DSTS-1:0]                 valid_out,
  output logic [NUM_DSTS-1:0][DATAW-1:0]      data_out,
  output logic [NUM_DSTS-1:0][SRC_WIDTH-1:0]  src_out,
  input  logic [NUM_DSTS-1:0]                 ready_out,
  output logic [PERF_CTR_BITS-1:0]            collisions,
  output logic [PERF_CTR_BITS-1:0]            drops
);

  localparam int CNTW = $clog2(NUM_SRCS + 1);

  logic [NUM_SRCS-1:0]                     inRange, dropReq, collide;
  logic [NUM_DSTS-1:0][NUM_SRCS-1:0]       req;
  logic [NUM_DSTS-1:0][SRC_WIDTH-1:0]      winner, hiWin, loWin;
  logic [NUM_DSTS-1:0]                     hiAny, anyReq, full, grant, pop;
  logic [NUM_DSTS-1:0][SRC_WIDTH-1:0]      ptr_q, ptr_d;
  logic [NUM_DSTS-1:0][1:0]                count_q, count_d;
  logic [NUM_DSTS-1:0]                     wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [NUM_DSTS-1:0][1:0][DATAW-1:0]     bufData_q;
  logic [NUM_DSTS-1:0][1:0][SRC_WIDTH-1:0] bufSrc_q;
  logic [CNTW-1:0]                         collCnt_q, collCnt_d, dropCnt_q, dropCnt_d;
  logic [PERF_CTR_BITS-1:0]                collisions_q, drops_q;

  // With a single destination the index field is ignored and nothing is ever out of range.
  always_comb begin
    for (int s = 0; s < NUM_SRCS; s++) begin
      inRange[s] = (NUM_DSTS == 1) || (int'(dst_in[s]) < NUM_DSTS);
      dropReq[s] = valid_in[s] && !inRange[s];
    end
    for (int d = 0; d < NUM_DSTS; d++) begin
      for (int s = 0; s < NUM_SRCS; s++) begin
        req[d][s] = valid_in[s] && inRange[s] && ((NUM_DSTS == 1) || (int'(dst_in[s]) == d));
      end
    end
  end

  // Round-robin: lowest requester at or above the pointer, else lowest overall (wrap-around).
  always_comb begin
    for (int d = 0; d < NUM_DSTS; d++) begin
      hiAny[d]  = 1'b0;
      anyReq[d] = 1'b0;
      hiWin[d]  = '0;
      loWin[d]  = '0;
      for (int s = NUM_SRCS - 1; s >= 0; s--) begin
        if (req[d][s]) begin
          loWin[d]  = SRC_WIDTH'(s);
          anyReq[d] = 1'b1;
          if (s >= int'(ptr_q[d])) begin
            hiWin[d] = SRC_WIDTH'(s);
            hiAny[d] = 1'b1;
          end
        end
      end
      winner[d]  = (NUM_SRCS == 1) ? '0 : (hiAny[d] ? hiWin[d] : loWin[d]);
      full[d]    = (count_q[d] == 2'd2);
      grant[d]   = anyReq[d] && !full[d];
      pop[d]     = valid_out[d] && ready_out[d];
      count_d[d] = count_q[d] + {1'b0, grant[d]} - {1'b0, pop[d]};
      wrPtr_d[d] = wrPtr_q[d] ^ grant[d];
      rdPtr_d[d] = rdPtr_q[d] ^ pop[d];
      if (grant[d] && (NUM_SRCS > 1)) begin
        ptr_d[d] = (int'(winner[d]) == NUM_SRCS - 1) ? '0 : winner[d] + SRC_WIDTH'(1);
      end else begin
        ptr_d[d] = ptr_q[d];
      end
    end
  end

  // A collision is a source that lost its destination to another grant, not a full-buffer stall.
  always_comb begin
    ready_in  = ~inRange;
    collCnt_d = '0;
    dropCnt_d = '0;
    for (int d = 0; d < NUM_DSTS; d++) begin
      for (int s = 0; s < NUM_SRCS; s++) begin
        if (grant[d] && (int'(winner[d]) == s)) begin
          ready_in[s] = 1'b1;
        end
      end
    end
    for (int s = 0; s < NUM_SRCS; s++) begin
      collide[s] = 1'b0;
      for (int d = 0; d < NUM_DSTS; d++) begin
        if (req[d][s] && grant[d] && (int'(winner[d]) != s)) begin
          collide[s] = 1'b1;
        end
      end
      collCnt_d = collCnt_d + CNTW'(collide[s]);
      dropCnt_d = dropCnt_d + CNTW'(dropReq[s]);
    end
  end

  always_comb begin
    for (int d = 0; d < NUM_DSTS; d++) begin
      valid_out[d] = (count_q[d] != 2'd0);
      data_out[d]  = bufData_q[d][rdPtr_q[d]];
      src_out[d]   = bufSrc_q[d][rdPtr_q[d]];
    end
  end

  // Per-cycle event counts are staged one cycle before accumulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q        <= '0;
      count_q      <= '0;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      collCnt_q    <= '0;
      dropCnt_q    <= '0;
      collisions_q <= '0;
      drops_q      <= '0;
    end else begin
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      collCnt_q    <= collCnt_d;
      dropCnt_q    <= dropCnt_d;
      collisions_q <= collisions_q + PERF_CTR_BITS'(collCnt_q);
      drops_q      <= drops_q + PERF_CTR_BITS'(dropCnt_q);
    end
  end

  always_ff @(posedge clk) begin
    for (int d = 0; d < NUM_DSTS; d++) begin
      if (grant[d]) begin
        bufData_q[d][wrPtr_q[d]] <= data_in[winner[d]];
        bufSrc_q[d][wrPtr_q[d]]  <= winner[d];
      end
    end
  end

  assign collisions = collisions_q;
  assign drops      = drops_q;

endmodule
